// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared constants, types and helper functions for the Canny NMS window
package canny_pkg;

  localparam int NBIT       = 8;
  localparam int FRAC_BITS  = 10;
  localparam int NBIT_SOBEL = 11;
  localparam int NBIT_MAG   = 12;
  localparam int TAN22_NUM  = 53;
  localparam int TAN67_NUM  = 309;
  localparam int TAN_DEN    = 128;
  // Nine products of NBIT x FRAC_BITS plus four bits of accumulation growth.
  localparam int ACC_W      = NBIT + FRAC_BITS + 4;
  localparam int RATIO_W    = 20;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_t;

  typedef logic [NBIT-1:0]                      pixel_t;
  typedef logic [6:0][6:0][NBIT-1:0]            window7_t;
  typedef logic [2:0][2:0][NBIT-1:0]            window3_t;
  typedef logic [2:0][2:0][FRAC_BITS-1:0]       kernel_t;
  typedef logic [2:0][2:0][NBIT_MAG-1:0]        mag_win_t;
  typedef logic signed [NBIT_SOBEL-1:0]         sobel_t;

  // (p0 + 2*p1 + p2) - (n0 + 2*n1 + n2); magnitude never exceeds 1020.
  function automatic sobel_t sobel_diff(pixel_t p0, pixel_t p1, pixel_t p2,
                                        pixel_t n0, pixel_t n1, pixel_t n2);
    logic [NBIT+1:0] pos;
    logic [NBIT+1:0] neg;
    pos = (NBIT+2)'(p0) + {1'b0, p1, 1'b0} + (NBIT+2)'(p2);
    neg = (NBIT+2)'(n0) + {1'b0, n1, 1'b0} + (NBIT+2)'(n2);
    return $signed({1'b0, pos}) - $signed({1'b0, neg});
  endfunction

  function automatic logic [NBIT_SOBEL-1:0] abs_s(sobel_t v);
    return v[NBIT_SOBEL-1] ? NBIT_SOBEL'(-v) : NBIT_SOBEL'(v);
  endfunction

  function automatic dir_t quant_dir(sobel_t gx, sobel_t gy);
    logic [RATIO_W-1:0] ay_s;
    logic [RATIO_W-1:0] ax_lo;
    logic [RATIO_W-1:0] ax_hi;
    ay_s  = RATIO_W'(abs_s(gy)) * RATIO_W'(TAN_DEN);
    ax_lo = RATIO_W'(abs_s(gx)) * RATIO_W'(TAN22_NUM);
    ax_hi = RATIO_W'(abs_s(gx)) * RATIO_W'(TAN67_NUM);
    if (ay_s <= ax_lo)
      return DIR_0;
    else if (ay_s >= ax_hi)
      return DIR_90;
    else if (gx[NBIT_SOBEL-1] == gy[NBIT_SOBEL-1])
      return DIR_45;
    else
      return DIR_135;
  endfunction

endpackage

// File: rtl/canny_nms_window_if.sv
// rtl/canny_nms_window_if.sv - window/kernel input and NMS result bundle
interface canny_nms_window_if;
  import canny_pkg::*;

  window7_t               i_data;
  logic                   i_data_valid;
  kernel_t                i_kernel;
  logic                   i_kernel_valid;
  logic [NBIT_MAG-1:0]    o_nms;
  dir_t                   o_dir;
  logic                   o_valid;

  modport master (
    output i_data, i_data_valid, i_kernel, i_kernel_valid,
    input  o_nms, o_dir, o_valid
  );

  modport slave (
    input  i_data, i_data_valid, i_kernel, i_kernel_valid,
    output o_nms, o_dir, o_valid
  );

endinterface

// File: rtl/gauss3x3_cell.sv
// rtl/gauss3x3_cell.sv - one registered 3x3 Gaussian tap: MAC, shift, saturate
module gauss3x3_cell
  import canny_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  window3_t pix,
  input  kernel_t  kernel,
  output pixel_t   g
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] shifted;
  pixel_t           sat;

  always_comb begin
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = acc + ACC_W'(pix[i][j]) * ACC_W'(kernel[i][j]);
      end
    end
    shifted = acc >> FRAC_BITS;
    sat     = (|shifted[ACC_W-1:NBIT]) ? '1 : shifted[NBIT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      g <= '0;
    else
      g <= sat;
  end

endmodule

// File: rtl/canny_nms_window.sv
// rtl/canny_nms_window.sv - 7x7 window to NMS magnitude: Gaussian, Sobel, mag/dir, NMS
module canny_nms_window
  import canny_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  canny_nms_window_if.slave  bus
);

  kernel_t                          kernel_q;
  wire [4:0][4:0][NBIT-1:0]         g;
  logic [2:0][2:0][NBIT_SOBEL-1:0]  gx_q;
  logic [2:0][2:0][NBIT_SOBEL-1:0]  gy_q;
  mag_win_t                         mag_q;
  dir_t                             dir_q;
  logic [2:0]                       valid_q;
  logic [NBIT_MAG-1:0]              nb_a;
  logic [NBIT_MAG-1:0]              nb_b;
  logic                             keep;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      kernel_q <= '0;
    else if (bus.i_kernel_valid)
      kernel_q <= bus.i_kernel;
  end

  for (genvar r = 0; r < 5; r++) begin : g_row
    for (genvar c = 0; c < 5; c++) begin : g_col
      window3_t win;
      always_comb begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            win[i][j] = bus.i_data[r+i][c+j];
          end
        end
      end
      gauss3x3_cell u_cell (
        .clk    (i_clk),
        .rst    (i_rst),
        .pix    (win),
        .kernel (kernel_q),
        .g      (g[r][c])
      );
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gx_q <= '0;
      gy_q <= '0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          gx_q[r][c] <= sobel_diff(g[r][c+2], g[r+1][c+2], g[r+2][c+2],
                                   g[r][c],   g[r+1][c],   g[r+2][c]);
          gy_q[r][c] <= sobel_diff(g[r+2][c], g[r+2][c+1], g[r+2][c+2],
                                   g[r][c],   g[r][c+1],   g[r][c+2]);
        end
      end
    end
  end

  // Only the centre direction steers suppression, so only it is kept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mag_q <= '0;
      dir_q <= DIR_0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          mag_q[r][c] <= {1'b0, abs_s(gx_q[r][c])} + {1'b0, abs_s(gy_q[r][c])};
        end
      end
      dir_q <= quant_dir(gx_q[1][1], gy_q[1][1]);
    end
  end

  always_comb begin
    nb_a = mag_q[1][0];
    nb_b = mag_q[1][2];
    case (dir_q)
      DIR_0:   begin nb_a = mag_q[1][0]; nb_b = mag_q[1][2]; end
      DIR_45:  begin nb_a = mag_q[0][0]; nb_b = mag_q[2][2]; end
      DIR_90:  begin nb_a = mag_q[0][1]; nb_b = mag_q[2][1]; end
      DIR_135: begin nb_a = mag_q[0][2]; nb_b = mag_q[2][0]; end
      default: begin nb_a = mag_q[1][0]; nb_b = mag_q[1][2]; end
    endcase
    keep = (mag_q[1][1] >= nb_a) && (mag_q[1][1] >= nb_b);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q     <= '0;
      bus.o_nms   <= '0;
      bus.o_dir   <= DIR_0;
      bus.o_valid <= 1'b0;
    end else begin
      valid_q     <= {valid_q[1:0], bus.i_data_valid};
      bus.o_nms   <= keep ? mag_q[1][1] : '0;
      bus.o_dir   <= dir_q;
      bus.o_valid <= valid_q[2];
    end
  end

endmodule

// File: tb/tb_canny_nms_window.sv
// tb/tb_canny_nms_window.sv - scoreboard bench for canny_nms_window with directed windows
module tb_canny_nms_window;
  import canny_pkg::*;

  typedef struct {
    int id;
    int nms;
    int dir;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  int   next_id = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  canny_nms_window_if bus ();

  canny_nms_window dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // kind 0: uniform v; 1: 254 where col>=v; 2: 254 where row>=v; 3: 254 where row+col>=v
  function automatic window7_t mk(input int kind, input int v);
    window7_t w;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 7; c++) begin
        case (kind)
          0:       w[r][c] = 8'(v);
          1:       w[r][c] = (c >= v) ? 8'd254 : 8'd0;
          2:       w[r][c] = (r >= v) ? 8'd254 : 8'd0;
          default: w[r][c] = (r + c >= v) ? 8'd254 : 8'd0;
        endcase
      end
    end
    return w;
  endfunction

  function automatic kernel_t kc(input int k);
    kernel_t t;
    t = '0;
    t[1][1] = FRAC_BITS'(k);
    return t;
  endfunction

  task automatic expect_out(input int nms, input int dir);
    exp_t e;
    e.id  = next_id;
    e.nms = nms;
    e.dir = dir;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic drive(input window7_t w, input logic v, input logic kv, input kernel_t k);
    bus.i_data         = w;
    bus.i_data_valid   = v;
    bus.i_kernel_valid = kv;
    bus.i_kernel       = k;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk(0, 0), 1'b0, 1'b0, kc(0));
  endtask

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("nms[%0d]", mon_e.id), int'(bus.o_nms), mon_e.nms);
        check($sformatf("dir[%0d]", mon_e.id), int'(bus.o_dir), mon_e.dir);
      end
    end
  end

  initial begin
    rst                = 1'b1;
    bus.i_data         = mk(0, 200);
    bus.i_data_valid   = 1'b1;
    bus.i_kernel       = kc(512);
    bus.i_kernel_valid = 1'b0;

    for (int i = 0; i < 2; i++) begin
      drive(mk(0, 200), 1'b1, 1'b0, kc(0));
      check("rst_valid", int'(bus.o_valid), 0);
      check("rst_nms", int'(bus.o_nms), 0);
      check("rst_dir", int'(bus.o_dir), 0);
    end
    rst = 1'b0;

    // No kernel loaded yet: windows flow through but the magnitude stays 0.
    for (int i = 0; i < 4; i++) begin
      expect_out(0, 0);
      drive(mk(0, 200), 1'b1, 1'b0, kc(0));
      if (i < 3) check("post_rst_latency", int'(bus.o_valid), 0);
    end
    idle(5);

    drive(mk(0, 0), 1'b0, 1'b1, kc(512));
    expect_out(0, 0);   drive(mk(0, 200), 1'b1, 1'b0, kc(0));
    expect_out(508, 0); drive(mk(1, 4),   1'b1, 1'b0, kc(0));
    expect_out(0, 0);   drive(mk(1, 5),   1'b1, 1'b0, kc(0));
    expect_out(508, 2); drive(mk(2, 4),   1'b1, 1'b0, kc(0));
    expect_out(762, 1); drive(mk(3, 7),   1'b1, 1'b0, kc(0));
    idle(6);

    // Kernel swap mid-stream: the window on the load edge still sees 512.
    expect_out(508, 0); drive(mk(1, 4), 1'b1, 1'b0, kc(0));
    expect_out(508, 0); drive(mk(1, 4), 1'b1, 1'b0, kc(0));
    expect_out(508, 0); drive(mk(1, 4), 1'b1, 1'b1, kc(256));
    expect_out(252, 0); drive(mk(1, 4), 1'b1, 1'b0, kc(0));
    expect_out(252, 0); drive(mk(1, 4), 1'b1, 1'b0, kc(0));
    expect_out(252, 0); drive(mk(1, 4), 1'b1, 1'b0, kc(0));
    idle(6);

    for (int i = 0; i < 3; i++) drive(mk(1, 4), 1'b1, 1'b0, kc(0));
    rst = 1'b1;
    drive(mk(1, 4), 1'b1, 1'b0, kc(0));
    check("midrst_valid", int'(bus.o_valid), 0);
    check("midrst_nms", int'(bus.o_nms), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out(0, 0);
      drive(mk(1, 4), 1'b1, 1'b0, kc(0));
    end
    expect_out(0, 0);   drive(mk(1, 4), 1'b1, 1'b1, kc(512));
    expect_out(508, 0); drive(mk(1, 4), 1'b1, 1'b0, kc(0));
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
